// File: rtl/dial_pkg.sv
// Shared types, dial codes and accumulator saturation for the dial pulse generator.
package dial_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [1:0] DIAL_IDLE = 2'b11;
  localparam logic [1:0] DIAL_DOWN = 2'b01;
  localparam logic [1:0] DIAL_UP   = 2'b10;

  // Adds b to a and clamps the exact sum to +/-(2^(acc_w-1)-1).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned acc_w);
    logic signed [31:0] lim;
    logic signed [31:0] sum;
    lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    sum = a + b;
    if (sum > lim) return lim;
    if (sum < -lim) return -lim;
    return sum;
  endfunction

endpackage

// File: rtl/dial_step_repeat.sv
// Digital up/down press detection with auto-repeat; emits a one-cycle signed +/-1 step.
module dial_step_repeat #(
  parameter int unsigned REPEAT_CYCLES = 24000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              dig_up,
  input  logic              dig_down,
  output logic signed [1:0] step
);

  localparam int unsigned CW = $clog2(REPEAT_CYCLES + 1);

  logic [CW-1:0] cnt, cnt_next;
  logic          held, held_up;
  logic          one_hot, fire;

  always_comb begin
    one_hot  = enable & (dig_up ^ dig_down);
    // A direction change while still one-hot counts as a fresh press.
    fire     = one_hot & (~held | (held_up != dig_up) | (cnt == CW'(REPEAT_CYCLES)));
    cnt_next = '0;
    if (one_hot) cnt_next = fire ? CW'(1) : cnt + CW'(1);
    step = 2'sd0;
    if (fire) step = dig_up ? 2'sd1 : -2'sd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      held    <= 1'b0;
      held_up <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      held    <= one_hot;
      held_up <= dig_up;
    end
  end

endmodule

// File: rtl/dial_pulse_gen.sv
// Converts spinner deltas and held up/down into timed active-low dial pulses.
module dial_pulse_gen #(
  parameter int unsigned PULSE_CYCLES  = 6000,
  parameter int unsigned GAP_CYCLES    = 6000,
  parameter int unsigned REPEAT_CYCLES = 24000,
  parameter int unsigned ACC_W         = 10
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       reverse,
  input  logic [8:0] spin_in,
  input  logic       dig_up,
  input  logic       dig_down,
  output logic [1:0] dial,
  output logic       busy
);

  import dial_pkg::*;

  state_t                   state, state_next;
  logic [15:0]              cnt, cnt_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic                     dir_up, dir_up_next;
  logic                     spin_q, armed;
  logic                     spin_evt;
  logic [1:0]               dial_next;
  logic signed [1:0]        step;
  logic signed [31:0]       delta, consume;

  dial_step_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_repeat (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .enable   (enable),
    .dig_up   (dig_up),
    .dig_down (dig_down),
    .step     (step)
  );

  always_comb begin
    // armed keeps a toggle present at reset release from counting as a sample.
    spin_evt    = enable & armed & (spin_in[8] ^ spin_q);
    delta       = spin_evt ? {{24{spin_in[7]}}, spin_in[7:0]} : '0;
    state_next  = state;
    cnt_next    = cnt;
    dir_up_next = dir_up;
    consume     = '0;
    case (state)
      IDLE: if (acc != '0) begin
        state_next  = PULSE;
        cnt_next    = '0;
        dir_up_next = ~acc[ACC_W-1];
        consume     = acc[ACC_W-1] ? 32'sd1 : -32'sd1;
      end
      PULSE: if (cnt == 16'(PULSE_CYCLES - 1)) begin
        state_next = GAP;
        cnt_next   = '0;
      end else cnt_next = cnt + 16'd1;
      GAP: if (cnt == 16'(GAP_CYCLES - 1)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else cnt_next = cnt + 16'd1;
      default: state_next = IDLE;
    endcase
    // Spin, digital and consume contributions are summed exactly, then saturated once.
    acc_next = ACC_W'(sat_add(32'(acc), delta + 32'(step) + consume, ACC_W));
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      acc_next   = '0;
    end
    dial_next = DIAL_IDLE;
    if (state_next == PULSE) dial_next = (dir_up_next ^ reverse) ? DIAL_UP : DIAL_DOWN;
    busy = (state != IDLE) || (acc != '0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      dir_up <= 1'b0;
      spin_q <= 1'b0;
      armed  <= 1'b0;
      dial   <= DIAL_IDLE;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      acc    <= acc_next;
      dir_up <= dir_up_next;
      spin_q <= spin_in[8];
      armed  <= 1'b1;
      dial   <= dial_next;
    end
  end

endmodule

// File: tb/tb_dial_pulse_gen.sv
// Directed self-checking bench for dial_pulse_gen with shortened pulse/gap/repeat timing.
module tb_dial_pulse_gen;

  localparam int P = 20;
  localparam int G = 20;
  localparam int R = 80;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       reverse = 1'b0;
  logic [8:0] spin_in = '0;
  logic       dig_up  = 1'b0;
  logic       dig_down = 1'b0;
  logic [1:0] dial;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_sys = ~clk_sys;

  dial_pulse_gen #(
    .PULSE_CYCLES  (P),
    .GAP_CYCLES    (G),
    .REPEAT_CYCLES (R),
    .ACC_W         (10)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .enable   (enable),
    .reverse  (reverse),
    .spin_in  (spin_in),
    .dig_up   (dig_up),
    .dig_down (dig_down),
    .dial     (dial),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic spin(input logic signed [7:0] d);
    spin_in = {~spin_in[8], d};
  endtask

  task automatic wait_pulse(output logic [1:0] code, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (dial == 2'b11 && waited < 400);
    code = dial;
  endtask

  task automatic pulse_len(output int len);
    logic [1:0] code;
    code = dial;
    len = 0;
    do begin
      len++;
      tick();
    end while (dial == code && len < 400);
  endtask

  task automatic expect_pulse(input string tag, input logic [1:0] exp_code, input int exp_wait);
    logic [1:0] code;
    int w, len;
    wait_pulse(code, w);
    check({tag, "_wait"}, w, exp_wait);
    check({tag, "_code"}, code, exp_code);
    pulse_len(len);
    check({tag, "_len"}, len, P);
  endtask

  task automatic count_pulses(input int cycles, inout int n_up, inout int n_dn);
    logic [1:0] prev;
    for (int i = 0; i < cycles; i++) begin
      prev = dial;
      tick();
      if (prev == 2'b11 && dial == 2'b10) n_up++;
      if (prev == 2'b11 && dial == 2'b01) n_dn++;
    end
  endtask

  initial begin
    int nu, nd;

    // Reset state
    repeat (3) tick();
    check("rst_dial", dial, 2'b11);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_dial", dial, 2'b11);
    check("post_rst_busy", busy, 1'b0);
    enable = 1'b1;
    tick();

    // +3: three up pulses, back-to-back spacing G+1 idle cycles
    spin(8'sd3);
    expect_pulse("p3a", 2'b10, 2);
    expect_pulse("p3b", 2'b10, G + 1);
    expect_pulse("p3c", 2'b10, G + 1);
    repeat (G - 1) tick();
    check("p3_busy_in_gap", busy, 1'b1);
    tick();
    check("p3_busy_done", busy, 1'b0);
    nu = 0; nd = 0;
    count_pulses(60, nu, nd);
    check("p3_no_extra", nu + nd, 0);

    // -2 reversed, then -2 normal
    reverse = 1'b1;
    spin(-8'sd2);
    expect_pulse("m2r_a", 2'b10, 2);
    expect_pulse("m2r_b", 2'b10, G + 1);
    repeat (G + 5) tick();
    check("m2r_busy", busy, 1'b0);
    reverse = 1'b0;
    spin(-8'sd2);
    expect_pulse("m2_a", 2'b01, 2);
    expect_pulse("m2_b", 2'b01, G + 1);
    repeat (G + 5) tick();
    check("m2_busy", busy, 1'b0);

    // Held digital up: steps at press, +R, +2R
    nu = 0; nd = 0;
    dig_up = 1'b1;
    count_pulses(200, nu, nd);
    dig_up = 1'b0;
    count_pulses(200, nu, nd);
    check("dig_up_pulses", nu, 3);
    check("dig_down_pulses", nd, 0);
    check("dig_busy", busy, 1'b0);

    // Saturation with eight consecutive +127 samples
    spin(8'sd127);
    tick();
    check("sat_first", dut.acc, 127);
    for (int i = 1; i < 8; i++) begin
      spin(8'sd127);
      tick();
    end
    check("sat_acc", dut.acc, 511);
    check("sat_dial", dial, 2'b10);
    check("sat_busy", busy, 1'b1);
    spin(8'sd127);
    tick();
    check("sat_no_wrap", dut.acc, 511);

    // Drop enable mid-pulse
    repeat (4) tick();
    check("mid_pulse_dial", dial, 2'b10);
    enable = 1'b0;
    tick();
    check("dis_dial", dial, 2'b11);
    check("dis_busy", busy, 1'b0);
    check("dis_acc", dut.acc, 0);

    // Toggle while disabled is discarded
    spin(8'sd5);
    tick();
    tick();
    enable = 1'b1;
    nu = 0; nd = 0;
    count_pulses(100, nu, nd);
    check("dis_spin_pulses", nu + nd, 0);
    check("dis_spin_busy", busy, 1'b0);

    // -1 sample coincident with IDLE consume of acc=+1
    spin(8'sd1);
    tick();
    check("coin_acc1", dut.acc, 1);
    spin(-8'sd1);
    tick();
    check("coin_acc", dut.acc, -1);
    check("coin_dial", dial, 2'b10);
    begin
      int len;
      pulse_len(len);
      check("coin_up_len", len, P);
    end
    expect_pulse("coin_down", 2'b01, G + 1);
    repeat (G + 5) tick();
    check("coin_busy", busy, 1'b0);
    check("coin_acc_end", dut.acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
